// File: rtl/seq_detector_param.sv
// Programmable serial Mealy sequence detector: 1..MAX_LEN bit pattern, optional
// overlap, input-valid qualifier and a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL = {CNT_W{1'b1}};
    localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(3'b101);
    localparam logic [LEN_W-1:0]   LEN_RST  = LEN_W'(3);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic [MAX_LEN:0]   window;
    logic [MAX_LEN:0]   mask;
    logic               hit;
    logic               filled;

    // A length of zero means a single-bit pattern; oversize lengths pin to MAX_LEN.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0) begin
            return LEN_ONE;
        end else if (l > LEN_MAX) begin
            return LEN_MAX;
        end
        return l;
    endfunction

    function automatic logic [MAX_LEN:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_LEN:0] m;
        m = '0;
        for (int i = 0; i <= MAX_LEN; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    // The incoming bit completes the window, so a match is flagged in its own cycle.
    always_comb begin
        window = {hist_q, in};
        mask   = len_mask(len_q);
        hit    = ((window ^ {1'b0, pat_q}) & mask) == '0;
        filled = fill_q >= (len_q - LEN_ONE);
        out    = en & ~cfg_load & filled & hit;
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = clamp_len(cfg_len);
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = {hist_q[MAX_LEN-2:0], in};
            if (out && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_MAX) begin
                fill_d = fill_q + LEN_ONE;
            end
        end
    end

    // Clear beats a coincident match; the counter sticks at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= PAT_RST;
            len_q  <= LEN_RST;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign match_count = cnt_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: the driver queues hand-computed
// expectations, the monitor pops and compares them on the falling edge.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset;
    logic               en;
    logic               in_b;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .in          (in_b),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  o;
        bit    cc;
        int    c;
        logic  s;
        string nm;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: every queued expectation is checked at the falling edge.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                n_vec++;
                if (out !== it.o) begin
                    n_fail++;
                    $display("FAIL %s out: got %b want %b", it.nm, out, it.o);
                end
                if (it.cc) begin
                    n_vec++;
                    if (match_count !== CNT_W'(it.c)) begin
                        n_fail++;
                        $display("FAIL %s match_count: got %0d want %0d", it.nm, match_count, it.c);
                    end
                    n_vec++;
                    if (count_sat !== it.s) begin
                        n_fail++;
                        $display("FAIL %s count_sat: got %b want %b", it.nm, count_sat, it.s);
                    end
                end
            end
        end
    end

    task automatic push(input logic eo, input bit cc, input int ec, input logic es, input string nm);
        exp_t it;
        it.o = eo; it.cc = cc; it.c = ec; it.s = es; it.nm = nm;
        q.push_back(it);
    endtask

    task automatic bit_in(input logic b, input logic eo, input string nm);
        @(posedge clk); #1;
        en = 1'b1; in_b = b; cfg_load = 1'b0; cnt_clr = 1'b0;
        push(eo, 1'b0, 0, 1'b0, nm);
    endtask

    task automatic gap(input logic b, input string nm);
        @(posedge clk); #1;
        en = 1'b0; in_b = b; cfg_load = 1'b0; cnt_clr = 1'b0;
        push(1'b0, 1'b0, 0, 1'b0, nm);
    endtask

    task automatic chk_cnt(input int ec, input logic es, input string nm);
        @(posedge clk); #1;
        en = 1'b0; in_b = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        push(1'b0, 1'b1, ec, es, nm);
    endtask

    task automatic clr_cnt();
        @(posedge clk); #1;
        en = 1'b0; in_b = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b1;
    endtask

    // The load cycle drives en=1, in=1 to show the load masks the flag.
    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ov, input string nm);
        @(posedge clk); #1;
        en = 1'b1; in_b = 1'b1; cfg_load = 1'b1; cnt_clr = 1'b0;
        cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
        push(1'b0, 1'b0, 0, 1'b0, nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b0; in_b = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        push(1'b0, 1'b1, 0, 1'b0, nm);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] a5;
        reset = 1'b0; en = 1'b0; in_b = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // Legacy 101 overlapping defaults
        do_reset("rst0");
        bit_in(1, 0, "d101_b1"); bit_in(0, 0, "d101_b2"); bit_in(1, 1, "d101_b3");
        bit_in(0, 0, "d101_b4"); bit_in(1, 1, "d101_b5");
        chk_cnt(2, 0, "d101_cnt");

        // 1101 overlapping, then non-overlapping
        clr_cnt();
        load(8'b0000_1101, 4'd4, 1'b1, "ld1101o");
        bit_in(1, 0, "o1101_b1"); bit_in(1, 0, "o1101_b2"); bit_in(0, 0, "o1101_b3");
        bit_in(1, 1, "o1101_b4"); bit_in(1, 0, "o1101_b5"); bit_in(0, 0, "o1101_b6");
        bit_in(1, 1, "o1101_b7");
        chk_cnt(2, 0, "o1101_cnt");
        clr_cnt();
        load(8'b0000_1101, 4'd4, 1'b0, "ld1101n");
        bit_in(1, 0, "n1101_b1"); bit_in(1, 0, "n1101_b2"); bit_in(0, 0, "n1101_b3");
        bit_in(1, 1, "n1101_b4"); bit_in(1, 0, "n1101_b5"); bit_in(0, 0, "n1101_b6");
        bit_in(1, 0, "n1101_b7");
        chk_cnt(1, 0, "n1101_cnt");

        // en gap holds state
        do_reset("rst_gap");
        bit_in(1, 0, "gap_b1"); bit_in(0, 0, "gap_b2");
        gap(1, "gap_h1"); gap(1, "gap_h2"); gap(1, "gap_h3");
        bit_in(1, 1, "gap_b3");

        // Reset mid-pattern discards the partial match
        do_reset("rst_mid0");
        bit_in(1, 0, "mid_b1"); bit_in(0, 0, "mid_b2");
        do_reset("rst_mid1");
        bit_in(1, 0, "mid_b3"); bit_in(0, 0, "mid_b4"); bit_in(1, 1, "mid_b5");
        chk_cnt(1, 0, "mid_cnt");

        // Counter saturation with a single-bit pattern
        clr_cnt();
        load(8'h01, 4'd1, 1'b1, "ld_sat");
        bit_in(0, 0, "len1_zero");
        for (int i = 0; i < 254; i++) bit_in(1, 1, "sat_run");
        chk_cnt(254, 0, "sat_254");
        bit_in(1, 1, "sat_255");
        chk_cnt(255, 1, "sat_hit");
        bit_in(1, 1, "sat_h1"); bit_in(1, 1, "sat_h2"); bit_in(1, 1, "sat_h3");
        chk_cnt(255, 1, "sat_hold");
        @(posedge clk); #1;
        en = 1'b1; in_b = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b1;
        push(1'b1, 1'b0, 0, 1'b0, "clr_match");
        chk_cnt(0, 0, "clr_cnt");

        // cfg_len=0 acts as one; cfg_len=15 clamps to 8
        load(8'h01, 4'd0, 1'b0, "ld_len0");
        bit_in(1, 1, "len0_b1"); bit_in(0, 0, "len0_b2"); bit_in(1, 1, "len0_b3");
        clr_cnt();
        load(8'hA5, 4'd15, 1'b1, "ld_len15");
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) bit_in(a5[i], (i == 0), "a5_bit");
        bit_in(0, 0, "a5_tail");
        chk_cnt(1, 0, "a5_cnt");

        @(posedge clk); #1;
        en = 1'b0; cnt_clr = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Mealy serial sequence detector and the successor to the fixed 101 overlapping detector. It supports a runtime-programmable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, an input-valid qualifier and a saturating match counter. It sits on a 1-bit serial stream and flags each match in the same cycle as the completing bit. Reset defaults reproduce the legacy 101 overlapping behaviour.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match counter
LEN_W, $clog2(MAX_LEN+1), width of the cfg_len field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  serial bit valid; when low the block holds state and out=0
in  input  1  serial data bit
cfg_load  input  1  single-cycle pulse that loads the configuration and restarts detection
cfg_pattern  input  MAX_LEN  pattern; bit len-1 is received first and bit 0 last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_count
out  output  1  Mealy match flag, combinational
match_count  output  CNT_W  number of matches, saturating
count_sat  output  1  high when match_count equals all ones

Behaviour:
- Config registers: pat_q, len_q, ovl_q.
  - Reset (reset=0, asynchronous): pat_q = 3'b101 zero-extended, len_q = 3, ovl_q = 1. The history register, fill counter and match_count clear to 0. count_sat = 0; out = 0 while in reset.
  - cfg_len = 0 is treated as 1. cfg_len > MAX_LEN is clamped to MAX_LEN. The clamping applies at load.
- History hist[MAX_LEN-1:0] holds the newest bit at bit 0. Fill counter fill ranges 0..MAX_LEN and saturates at MAX_LEN.
- out (combinational, zero latency): out = en & ~cfg_load & (fill >= len_q-1) & (low len_q bits of {hist,in} == low len_q bits of pat_q).
- Rising edge, cfg_load=1 (highest priority):
  - Load pat_q, len_q and ovl_q from the cfg_* inputs.
  - Clear hist and fill.
  - en and in are ignored in that cycle.
  - match_count is unaffected unless cnt_clr is also high.
- Rising edge, en=1, cfg_load=0:
  - hist <= {hist[MAX_LEN-2:0], in}.
  - If out=1 and ovl_q=0: fill <= 0 (restart, no bit reuse). Otherwise fill <= min(fill+1, MAX_LEN).
- Rising edge, en=0: hist and fill hold. match_count only responds to cnt_clr.
- match_count:
  - Increments by 1 on each edge where out=1.
  - Holds at 2^CNT_W-1 when saturated.
  - cnt_clr=1 forces it to 0. cnt_clr wins over a simultaneous match, so that match is not counted.
- count_sat is registered and updates on the same edge as match_count (count_sat = next match_count == all ones).
- len_q = 1: every bit equal to pat_q[0] matches. Non-overlap mode gives the same result in this case.
- Reset mid-pattern discards any partial match. The first match after release needs len_q fresh bits.

Test Plan:
- Defaults after reset, en=1, in stream 1,0,1,0,1 -> out high on the 3rd and 5th bits; match_count = 2.
- cfg_load with pattern=8'b0000_1101, len=4, overlap=1, then stream 1,1,0,1,1,0,1 -> out on bits 4 and 7; count = 2. Repeat with overlap=0 -> out on bit 4 only; count = 1.
- Default config, stream 1,0 then en=0 for 3 cycles with in=1, then en=1, in=1 -> out=0 during the gap; out=1 on the final bit.
- Bits 1,0 fed, then reset pulsed low, then 1 -> no out. Then 0,1 -> out on the last bit; count = 1.
- CNT_W=2, default config, stream 1,0,1,0,1,0,1,0,1 (4 overlapping matches) -> match_count = 3, count_sat = 1. cnt_clr asserted with a match in the same cycle -> count = 0, count_sat = 0.
- cfg_len=0 with pattern bit0=1, then stream 1,0,1 -> out on bits 1 and 3. cfg_len=15 (MAX_LEN=8) -> len_q = 8; pattern 8'hA5 fed MSB-first -> single out on the 8th bit; out=0 in the cfg_load cycle.
